// File: rtl/dvs_event_assembler.sv
// DVS event assembler.
// Deserializes a 5-byte frame (HDR, X, Y, T_HI, T_LO) into an event word,
// buffers completed events in a small FIFO and hands them downstream over a
// valid/ready handshake. Malformed headers and stalled frames are counted in
// saturating debug counters, as are events lost to a full FIFO.
module dvs_event_assembler #(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        ev_ready,
    output logic        ev_valid,
    output logic [7:0]  ev_x,
    output logic [7:0]  ev_y,
    output logic        ev_p,
    output logic [15:0] ev_t,
    output logic        busy,
    output logic [7:0]  drop_cnt,
    output logic [7:0]  err_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = 33;   // {x[7:0], y[7:0], p, t[15:0]}
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GET_X  = 3'd1,
        GET_Y  = 3'd2,
        GET_TH = 3'd3,
        GET_TL = 3'd4
    } state_t;

    // Saturating 8-bit increment for the debug counters.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'hFF) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

    // Frame assembly state.
    state_t      state_q, state_d;
    logic [7:0]  x_q, x_d;
    logic [7:0]  y_q, y_d;
    logic        p_q, p_d;
    logic [7:0]  th_q, th_d;
    logic [15:0] tmo_q, tmo_d;

    // FIFO state; pointers carry one extra bit to tell full from empty.
    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;

    // Debug counters.
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    // Internal strobes.
    logic          push_s;
    logic          bad_hdr_s;
    logic          tmo_hit_s;
    logic          full_s;
    logic          empty_s;
    logic          pop_s;
    logic          wr_en_s;
    logic          drop_s;
    logic [EW-1:0] entry_s;
    logic [EW-1:0] head_s;

    // Frame FSM: byte acceptance, field capture and inter-byte timeout.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        p_d       = p_q;
        th_d      = th_q;
        tmo_d     = tmo_q;
        push_s    = 1'b0;
        bad_hdr_s = 1'b0;
        tmo_hit_s = 1'b0;
        if ((state_q != IDLE) && !byte_valid) begin
            // Mid-frame stall: count idle cycles, abort once the limit is hit.
            if (tmo_q == TMO_LAST) begin
                state_d   = IDLE;
                tmo_d     = 16'd0;
                tmo_hit_s = 1'b1;
            end else begin
                tmo_d = tmo_q + 16'd1;
            end
        end else begin
            // Any accepted byte (and sitting in IDLE) clears the stall counter.
            tmo_d = 16'd0;
            case (state_q)
                IDLE: begin
                    if (byte_valid) begin
                        if (byte_in[7]) begin
                            p_d     = byte_in[0];
                            state_d = GET_X;
                        end else begin
                            bad_hdr_s = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                GET_X: begin
                    x_d     = byte_in;
                    state_d = GET_Y;
                end
                GET_Y: begin
                    y_d     = byte_in;
                    state_d = GET_TH;
                end
                GET_TH: begin
                    th_d    = byte_in;
                    state_d = GET_TL;
                end
                GET_TL: begin
                    // Last byte goes straight into the FIFO write data.
                    push_s  = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // FIFO control: write on push unless full without a simultaneous pop.
    always_comb begin
        full_s   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty_s  = (wr_ptr_q == rd_ptr_q);
        pop_s    = !empty_s && ev_ready;
        wr_en_s  = push_s && (!full_s || pop_s);
        drop_s   = push_s && full_s && !pop_s;
        entry_s  = {x_q, y_q, p_q, th_q, byte_in};
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en_s) begin
            mem_d[wr_ptr_q[AW-1:0]] = entry_s;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Saturating drop and error counters.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (drop_s) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
        if (bad_hdr_s || tmo_hit_s) begin
            err_cnt_d = sat_inc(err_cnt_q);
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Present the FIFO head; all event fields read zero while nothing is queued.
    always_comb begin
        head_s   = mem_q[rd_ptr_q[AW-1:0]];
        ev_valid = 1'b0;
        ev_x     = 8'd0;
        ev_y     = 8'd0;
        ev_p     = 1'b0;
        ev_t     = 16'd0;
        if (!empty_s) begin
            ev_valid = 1'b1;
            ev_x     = head_s[32:25];
            ev_y     = head_s[24:17];
            ev_p     = head_s[16];
            ev_t     = head_s[15:0];
        end else begin
            ev_valid = 1'b0;
        end
    end

    assign busy     = (state_q != IDLE);
    assign drop_cnt = drop_cnt_q;
    assign err_cnt  = err_cnt_q;

    // State register for the FSM, FIFO and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            x_q        <= 8'd0;
            y_q        <= 8'd0;
            p_q        <= 1'b0;
            th_q       <= 8'd0;
            tmo_q      <= 16'd0;
            mem_q      <= '{default: {EW{1'b0}}};
            wr_ptr_q   <= {(AW+1){1'b0}};
            rd_ptr_q   <= {(AW+1){1'b0}};
            drop_cnt_q <= 8'd0;
            err_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            p_q        <= p_d;
            th_q       <= th_d;
            tmo_q      <= tmo_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            drop_cnt_q <= drop_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_dvs_event_assembler.sv
// Self-checking bench for dvs_event_assembler: a table of frames with
// expected decodes plus hand-written multi-cycle sequences, all checked
// through a scoreboard queue of expected FIFO contents.
module tb_dvs_event_assembler;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        ev_ready;
    logic        ev_valid;
    logic [7:0]  ev_x;
    logic [7:0]  ev_y;
    logic        ev_p;
    logic [15:0] ev_t;
    logic        busy;
    logic [7:0]  drop_cnt;
    logic [7:0]  err_cnt;

    typedef struct packed {
        logic [7:0]  x;
        logic [7:0]  y;
        logic        p;
        logic [15:0] t;
    } ev_rec_t;

    typedef struct packed {
        logic [7:0] h;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] th;
        logic [7:0] tl;
        ev_rec_t    e;
    } vec_t;

    ev_rec_t    exp_q[$];
    logic [7:0] exp_drop = 8'd0;
    logic [7:0] exp_err  = 8'd0;
    int         total    = 0;
    int         bad      = 0;
    vec_t       tbl[4];

    dvs_event_assembler #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(255)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .ev_ready   (ev_ready),
        .ev_valid   (ev_valid),
        .ev_x       (ev_x),
        .ev_y       (ev_y),
        .ev_p       (ev_p),
        .ev_t       (ev_t),
        .busy       (busy),
        .drop_cnt   (drop_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] sat(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, check head/counters against the model,
    // then advance the model the way the DUT will advance at the next edge.
    task automatic cyc(input logic bv, input logic [7:0] b, input logic rdy,
                       input logic is_tl, input ev_rec_t e, input logic is_bad);
        logic    pop_m;
        logic    full_m;
        ev_rec_t h;
        @(negedge clk);
        byte_valid = bv;
        byte_in    = b;
        ev_ready   = rdy;
        #1;
        h = (exp_q.size() != 0) ? exp_q[0] : '0;
        chk("ev_valid", 32'(ev_valid), 32'(exp_q.size() != 0));
        chk("ev_x", 32'(ev_x), 32'(h.x));
        chk("ev_y", 32'(ev_y), 32'(h.y));
        chk("ev_p", 32'(ev_p), 32'(h.p));
        chk("ev_t", 32'(ev_t), 32'(h.t));
        chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
        chk("err_cnt", 32'(err_cnt), 32'(exp_err));
        pop_m  = (exp_q.size() != 0) && rdy;
        full_m = (exp_q.size() == DEPTH);
        if (pop_m) void'(exp_q.pop_front());
        if (bv && is_tl) begin
            if (!full_m || pop_m) exp_q.push_back(e);
            else exp_drop = sat(exp_drop);
        end
        if (bv && is_bad) exp_err = sat(exp_err);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, rdy, 1'b0, '0, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] h, input logic [7:0] x, input logic [7:0] y,
                              input logic [7:0] th, input logic [7:0] tl,
                              input logic rdy, input logic rdy_last, input ev_rec_t e);
        cyc(1'b1, h,  rdy,      1'b0, e, 1'b0);
        cyc(1'b1, x,  rdy,      1'b0, e, 1'b0);
        cyc(1'b1, y,  rdy,      1'b0, e, 1'b0);
        cyc(1'b1, th, rdy,      1'b0, e, 1'b0);
        cyc(1'b1, tl, rdy_last, 1'b1, e, 1'b0);
    endtask

    function automatic ev_rec_t mk(input logic [7:0] h, input logic [7:0] x, input logic [7:0] y,
                                   input logic [7:0] th, input logic [7:0] tl);
        ev_rec_t r;
        r.x = x;
        r.y = y;
        r.p = h[0];
        r.t = {th, tl};
        return r;
    endfunction

    initial begin
        tbl[0] = '{h:8'h81, x:8'h12, y:8'h34, th:8'hAB, tl:8'hCD, e:'{x:8'h12, y:8'h34, p:1'b1, t:16'hABCD}};
        tbl[1] = '{h:8'hFE, x:8'h80, y:8'hFF, th:8'h00, tl:8'h01, e:'{x:8'h80, y:8'hFF, p:1'b0, t:16'h0001}};
        tbl[2] = '{h:8'hFF, x:8'h00, y:8'h00, th:8'hFF, tl:8'hFF, e:'{x:8'h00, y:8'h00, p:1'b1, t:16'hFFFF}};
        tbl[3] = '{h:8'hC0, x:8'h7F, y:8'h81, th:8'h12, tl:8'h34, e:'{x:8'h7F, y:8'h81, p:1'b0, t:16'h1234}};

        rst_n      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        ev_ready   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ev_valid", 32'(ev_valid), 32'd0);
        chk("rst_ev_t", 32'(ev_t), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame: event visible the cycle after T_LO, gone after the pop.
        send_frame(8'h81, 8'h12, 8'h34, 8'hAB, 8'hCD, 1'b1, 1'b1, tbl[0].e);
        chk("lat_valid", 32'(ev_valid), 32'd1);
        chk("lat_x", 32'(ev_x), 32'h12);
        chk("lat_y", 32'(ev_y), 32'h34);
        chk("lat_p", 32'(ev_p), 32'd1);
        chk("lat_t", 32'(ev_t), 32'hABCD);
        idle(1, 1'b1);
        chk("after_pop_valid", 32'(ev_valid), 32'd0);

        // Table of frames sent back to back with the sink always ready.
        for (int i = 0; i < 4; i++)
            send_frame(tbl[i].h, tbl[i].x, tbl[i].y, tbl[i].th, tbl[i].tl, 1'b1, 1'b1, tbl[i].e);
        idle(2, 1'b1);
        chk("tbl_drop", 32'(drop_cnt), 32'd0);
        chk("tbl_err", 32'(err_cnt), 32'd0);

        // Six frames into a blocked sink: four held, two dropped.
        for (int i = 0; i < 6; i++)
            send_frame(8'h80 | 8'(i), 8'(i), 8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i), 1'b0, 1'b0,
                       mk(8'h80 | 8'(i), 8'(i), 8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i)));
        chk("six_drop", 32'(drop_cnt), 32'd2);
        chk("six_valid", 32'(ev_valid), 32'd1);
        idle(DEPTH + 2, 1'b1);
        chk("six_drained", 32'(ev_valid), 32'd0);

        // Full FIFO with a pop on the T_LO cycle: write allowed, no drop.
        for (int i = 0; i < DEPTH; i++)
            send_frame(8'h81, 8'(8'h40 + i), 8'h01, 8'h02, 8'(i), 1'b0, 1'b0,
                       mk(8'h81, 8'(8'h40 + i), 8'h01, 8'h02, 8'(i)));
        send_frame(8'h81, 8'hA5, 8'h5A, 8'hDE, 8'hAD, 1'b0, 1'b1, mk(8'h81, 8'hA5, 8'h5A, 8'hDE, 8'hAD));
        chk("fullpop_drop", 32'(drop_cnt), 32'd2);
        chk("fullpop_head_x", 32'(ev_x), 32'h41);
        send_frame(8'h80, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 1'b0, 1'b0, mk(8'h80, 8'hEE, 8'hEE, 8'hEE, 8'hEE));
        chk("still_full_drop", 32'(drop_cnt), 32'd3);
        idle(DEPTH + 2, 1'b1);

        // Stray byte in IDLE, then a good frame.
        cyc(1'b1, 8'h05, 1'b1, 1'b0, '0, 1'b1);
        chk("stray_busy", 32'(busy), 32'd0);
        send_frame(8'h81, 8'h21, 8'h22, 8'h23, 8'h24, 1'b1, 1'b1, mk(8'h81, 8'h21, 8'h22, 8'h23, 8'h24));
        chk("stray_err", 32'(err_cnt), 32'd1);
        idle(2, 1'b1);

        // Inter-byte timeout: alive after 254 idle cycles, aborted after 255.
        cyc(1'b1, 8'h80, 1'b1, 1'b0, '0, 1'b0);
        cyc(1'b1, 8'h10, 1'b1, 1'b0, '0, 1'b0);
        idle(254, 1'b1);
        chk("tmo_busy_254", 32'(busy), 32'd1);
        chk("tmo_err_254", 32'(err_cnt), 32'd1);
        idle(1, 1'b1);
        exp_err = sat(exp_err);
        chk("tmo_busy_255", 32'(busy), 32'd0);
        chk("tmo_err_255", 32'(err_cnt), 32'd2);
        chk("tmo_no_event", 32'(ev_valid), 32'd0);
        send_frame(8'h80, 8'h01, 8'h02, 8'h03, 8'h04, 1'b1, 1'b1, '{x:8'h01, y:8'h02, p:1'b0, t:16'h0304});
        chk("tmo_next_t", 32'(ev_t), 32'h0304);
        idle(2, 1'b1);

        // Asynchronous reset mid-frame with two events queued.
        send_frame(8'h81, 8'h51, 8'h52, 8'h53, 8'h54, 1'b0, 1'b0, mk(8'h81, 8'h51, 8'h52, 8'h53, 8'h54));
        send_frame(8'h80, 8'h61, 8'h62, 8'h63, 8'h64, 1'b0, 1'b0, mk(8'h80, 8'h61, 8'h62, 8'h63, 8'h64));
        cyc(1'b1, 8'h81, 1'b0, 1'b0, '0, 1'b0);
        cyc(1'b1, 8'h71, 1'b0, 1'b0, '0, 1'b0);
        cyc(1'b1, 8'h72, 1'b0, 1'b0, '0, 1'b0);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_valid", 32'(ev_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(ev_valid), 32'd0);
        chk("arst_x", 32'(ev_x), 32'd0);
        chk("arst_t", 32'(ev_t), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_drop", 32'(drop_cnt), 32'd0);
        chk("arst_err", 32'(err_cnt), 32'd0);
        exp_q.delete();
        exp_drop   = 8'd0;
        exp_err    = 8'd0;
        byte_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'h81, 8'h33, 8'h44, 8'h55, 8'h66, 1'b1, 1'b1, '{x:8'h33, y:8'h44, p:1'b1, t:16'h5566});
        chk("post_rst_y", 32'(ev_y), 32'h44);
        idle(2, 1'b1);

        // Error counter saturation.
        for (int i = 0; i < 300; i++) cyc(1'b1, 8'h05, 1'b1, 1'b0, '0, 1'b1);
        idle(1, 1'b1);
        chk("err_sat", 32'(err_cnt), 32'd255);
        chk("err_sat_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
